flag_branch_unit: RTL

// - EX-stage consumer of ALU flag outputs Z/N/V: holds the architectural flag register (FLAG[2:0] = {Z,V,N}).
// - Updates the flag register per opcode class.
// - Evaluates the 3-bit branch condition for B/BR in decode.
// - Sequences processor halt: HLT retire -> pipeline drain -> halted.
// - Sits between the ALU and the PC/fetch control logic.

---
 rtl/flag_branch_unit.sv | 81 ++++++++
 1 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural {Z,V,N} flag register, branch condition evaluation and halt drain sequencing.
// Optional build macro FLAG_FWD_EN: evaluate branches on forwarded EX flags instead of stalling.
module flag_branch_unit #(
    parameter int HALT_DRAIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       flush,
    input  logic [3:0] ex_opcode,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags,
    output logic       br_taken,
    output logic       br_stall,
    output logic       halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t     state, state_nx;
    logic [3:0] drain_cnt, cnt_nx;
    logic       wr_all, wr_z, upd, run, cond;
    logic [2:0] flags_nx, f;
    // Decode flag-writing classes and merge ALU flags into the next flag value
    always_comb begin
        wr_all   = ex_opcode inside {4'b0000, 4'b0001};
        wr_z     = ex_opcode inside {4'b0010, 4'b0100, 4'b0101, 4'b0110};
        upd      = (wr_all | wr_z) & ~flush;
        flags_nx = ~upd ? flags : wr_all ? {alu_z, alu_v, alu_n} : {alu_z, flags[1:0]};
    end
    // Halt sequencing: HLT starts the drain, counted only on advancing cycles
    always_comb begin
        state_nx = state;
        cnt_nx   = drain_cnt;
        if (state == RUN && !flush && ex_opcode == 4'b1111) begin
            state_nx = DRAIN;
            cnt_nx   = 4'd0;
        end else if (state == DRAIN) begin
            state_nx = (drain_cnt == 4'(HALT_DRAIN - 1)) ? HALTED : DRAIN;
            cnt_nx   = drain_cnt + 4'd1;
        end
    end
    // Branch resolution on registered or forwarded flags
    always_comb begin
        run = state == RUN;
`ifdef FLAG_FWD_EN
        f        = flags_nx;
        br_stall = 1'b0;
`else
        f        = flags;
        br_stall = br_valid & run & upd;
`endif
        case (br_cond)
            3'b000:  cond = ~f[2];
            3'b001:  cond = f[2];
            3'b010:  cond = ~f[2] & ~f[0];
            3'b011:  cond = f[0];
            3'b100:  cond = f[2] | (~f[2] & ~f[0]);
            3'b101:  cond = f[0] | f[2];
            3'b110:  cond = f[1];
            default: cond = 1'b1;
        endcase
        br_taken = br_valid & run & ~br_stall & cond;
    end
    // State, counter and flag registers advance only when the pipeline does; flags freeze once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags     <= 3'b000;
            state     <= RUN;
            drain_cnt <= 4'd0;
            halted    <= 1'b0;
        end else if (en) begin
            flags     <= (state == HALTED) ? flags : flags_nx;
            state     <= state_nx;
            drain_cnt <= cnt_nx;
            halted    <= state_nx == HALTED;
        end
    end
endmodule
